// File: rtl/milano_mdu.sv
// milano_mdu -- iterative RV32M multiply/divide unit (EX stage, beside the ALU).
//
// Multiply is shift-add and retires one multiplier bit per cycle. Divide is
// restoring and retires one quotient bit per cycle. Operands are converted to
// magnitudes on accept. Signs are re-applied in a single FIX cycle. Divide by
// zero and signed overflow (MIN_INT / -1) skip the iterations and complete in
// one cycle.
//
// Optional feature: define MILANO_MDU_EARLY_OUT_EN to enable early exit.
// A multiply leaves the loop once its remaining multiplier bits are all zero.
// DIVU/REMU with a < b complete immediately.
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   valid_i/ready_o  request handshake; md_op_i >= 8 is never accepted
//   md_op_i          MUL=0 MULH=1 MULSU=2 MULU=3 DIV=4 DIVU=5 REM=6 REMU=7
//   op_a_i, op_b_i   rs1 / rs2 operands
//   kill_i           abort the in-flight operation (ignored while idle)
//   result_o         result; changes only when an operation completes
//   valid_o          one-cycle completion pulse
//   busy_o           an operation is in flight
module milano_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       md_op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             kill_i,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o,
  output logic             busy_o
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULSU = 3'd2, OP_MULU = 3'd3,
                         OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM   = 3'd6, OP_REMU = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e               state;
  logic [2:0]           op_q;
  logic [2*WIDTH-1:0]   acc;      // mul: product, shifted in from the top; div: {rem, quot}
  logic [WIDTH-1:0]     opb_q;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]     mpl_q;    // remaining multiplier bits
  logic [CNT_W-1:0]     cnt_q;    // iterations completed
  logic                 neg_lo;   // negate product / quotient
  logic                 neg_rem;  // negate remainder (follows dividend)

  // Accept-time decode
  logic             accept, a_neg, b_neg, special;
  logic [WIDTH-1:0] a_mag, b_mag, special_res;

  // valid_o is the registered image of DONE, so the pulse lands in the cycle
  // after DONE. Holding ready low for that cycle keeps ready one cycle behind.
  assign ready_o = (state == S_IDLE) && !valid_o;
  assign busy_o  = (state != S_IDLE);
  assign accept  = valid_i && ready_o && !md_op_i[3];

  assign a_neg = op_a_i[WIDTH-1] && (md_op_i[2:0] == OP_MULH || md_op_i[2:0] == OP_MULSU ||
                                     md_op_i[2:0] == OP_DIV  || md_op_i[2:0] == OP_REM);
  assign b_neg = op_b_i[WIDTH-1] && (md_op_i[2:0] == OP_MULH || md_op_i[2:0] == OP_DIV ||
                                     md_op_i[2:0] == OP_REM);
  assign a_mag = a_neg ? -op_a_i : op_a_i;
  assign b_mag = b_neg ? -op_b_i : op_b_i;

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    case (md_op_i[2:0])
      OP_DIV: begin
        if (op_b_i == '0) begin
          special = 1'b1; special_res = '1;
        end else if (op_a_i == MIN_INT && op_b_i == '1) begin
          special = 1'b1; special_res = MIN_INT;
        end
      end
      OP_REM: begin
        if (op_b_i == '0) begin
          special = 1'b1; special_res = op_a_i;
        end else if (op_a_i == MIN_INT && op_b_i == '1) begin
          special = 1'b1; special_res = '0;
        end
      end
      OP_DIVU: begin
        if (op_b_i == '0) begin
          special = 1'b1; special_res = '1;
        end
`ifdef MILANO_MDU_EARLY_OUT_EN
        else if (op_a_i < op_b_i) begin
          special = 1'b1; special_res = '0;
        end
`endif
      end
      OP_REMU: begin
        if (op_b_i == '0) begin
          special = 1'b1; special_res = op_a_i;
        end
`ifdef MILANO_MDU_EARLY_OUT_EN
        else if (op_a_i < op_b_i) begin
          special = 1'b1; special_res = op_a_i;
        end
`endif
      end
      default: ;
    endcase
  end

  // Multiply step: add multiplicand into the high half, then shift the
  // whole accumulator right by one.
  logic [WIDTH:0] mul_sum;
  logic           mul_last;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mpl_q[0] ? opb_q : {WIDTH{1'b0}})};
`ifdef MILANO_MDU_EARLY_OUT_EN
  assign mul_last = (cnt_q == LAST_IT) || (mpl_q[WIDTH-1:1] == '0);
`else
  assign mul_last = (cnt_q == LAST_IT);
`endif

  // Restoring divide step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  logic [WIDTH:0]     div_rs;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  assign div_rs   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge   = div_rs >= {1'b0, opb_q};
  assign div_diff = div_rs[WIDTH-1:0] - opb_q;  // true difference is < divisor
  assign div_next = {(div_ge ? div_diff : div_rs[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

  // Sign fix-up and result select
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s, fix_res;
`ifdef MILANO_MDU_EARLY_OUT_EN
  // An early exit skipped (WIDTH - cnt) shifts; apply them here.
  assign prod = acc >> (CNT_W'(WIDTH) - cnt_q);
`else
  assign prod = acc;
`endif
  assign prod_s = neg_lo  ? -prod : prod;
  assign quot_s = neg_lo  ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_s  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:                     fix_res = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULSU, OP_MULU: fix_res = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:            fix_res = quot_s;
      default:                    fix_res = rem_s;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      op_q     <= '0;
      acc      <= '0;
      opb_q    <= '0;
      mpl_q    <= '0;
      cnt_q    <= '0;
      neg_lo   <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (state != S_IDLE && kill_i) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (accept) begin
            op_q    <= md_op_i[2:0];
            cnt_q   <= '0;
            neg_lo  <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            if (special) begin
              result_o <= special_res;
              state    <= S_DONE;
            end else if (md_op_i[2]) begin
              acc   <= {{WIDTH{1'b0}}, a_mag};
              opb_q <= b_mag;
              state <= S_DIV;
            end else begin
              acc   <= '0;
              opb_q <= a_mag;
              mpl_q <= b_mag;
              state <= S_MUL;
            end
          end
          S_MUL: begin
            acc   <= {mul_sum, acc[WIDTH-1:1]};
            mpl_q <= mpl_q >> 1;
            cnt_q <= cnt_q + 1'b1;
            if (mul_last) state <= S_FIX;
          end
          S_DIV: begin
            acc   <= div_next;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_IT) state <= S_FIX;
          end
          S_FIX: begin
            result_o <= fix_res;
            state    <= S_DONE;
          end
          S_DONE: begin
            valid_o <= 1'b1;
            state   <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_milano_mdu.sv
// Testbench for milano_mdu (WIDTH=32). Directed cases plus random operations
// are checked against a plain-arithmetic RV32M model. The model covers both
// the result and the completion latency.
module tb_milano_mdu;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  md_op_i;
  logic [31:0] op_a_i, op_b_i;
  logic        kill_i;
  logic [31:0] result_o;
  logic        valid_o;
  logic        busy_o;

  milano_mdu #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .md_op_i(md_op_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .kill_i(kill_i),
    .result_o(result_o), .valid_o(valid_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] last_res = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // RV32M result model
  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (op)
      4'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      4'd1: begin p = sa * sb; return p[63:32]; end
      4'd2: begin p = sa * ub; return p[63:32]; end
      4'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      4'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      4'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from the accept edge to the first cycle with valid_o high
  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] bm;
    int k;
    if (op >= 4 && b == 0) return 1;
    if ((op == 4 || op == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MILANO_MDU_EARLY_OUT_EN
    if ((op == 5 || op == 7) && a < b) return 1;
    if (op < 4) begin
      bm = (op == 1 && b[31]) ? -b : b;
      k = 1;
      for (int i = 0; i < 32; i++) if (bm[i]) k = i + 1;
      return k + 2;
    end
`endif
    bm = b;
    k = 34;
    return k;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit kill_same);
    logic [31:0] exp;
    int exp_lat, lat;
    bit got, rdy_low;
    exp     = ref_res(op, a, b);
    exp_lat = ref_lat(op, a, b);
    @(negedge clk_i);
    chk("ready_before", ready_o, 1);
    valid_i = 1'b1; md_op_i = op; op_a_i = a; op_b_i = b; kill_i = kill_same;
    @(posedge clk_i); #1;
    valid_i = 1'b0; kill_i = 1'b0;
    lat = 0; got = 0; rdy_low = (ready_o == 1'b0);
    while (!got && lat < 80) begin
      @(posedge clk_i); #1;
      lat++;
      if (ready_o) rdy_low = 0;
      if (valid_o) got = 1;
    end
    chk("valid_seen", got, 1);
    chk($sformatf("lat_op%0d", op), lat, exp_lat);
    chk($sformatf("res_op%0d_%0h_%0h", op, a, b), result_o, exp);
    chk("ready_low_in_flight", rdy_low, 1);
    @(posedge clk_i); #1;
    chk("valid_one_cycle", valid_o, 0);
    chk("ready_after", ready_o, 1);
    last_res = exp;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_i = 1'b1; valid_i = 1'b0; md_op_i = '0; op_a_i = '0; op_b_i = '0; kill_i = 1'b0;
    #12;
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_result", result_o, 0);
    @(negedge clk_i); rst_i = 1'b0;

    // Directed cases
    run_op(4'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(4'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(4'd4, -32'sd7, 32'd2, 0);
    run_op(4'd6, -32'sd7, 32'd2, 0);
    run_op(4'd5, 32'd100, 32'd7, 0);
    run_op(4'd7, 32'd100, 32'd7, 0);
    run_op(4'd4, 32'd5, 32'd0, 0);
    run_op(4'd6, 32'd5, 32'd0, 0);
    run_op(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(4'd5, 32'd9, 32'd0, 0);
    run_op(4'd7, 32'd9, 32'd0, 0);
    run_op(4'd0, 32'd5, 32'd1, 0);
    run_op(4'd5, 32'd3, 32'd10, 0);
    run_op(4'd7, 32'd3, 32'd10, 0);
    run_op(4'd0, 32'd6, 32'd9, 1);  // kill_i in IDLE with the accept

    // Kill a DIVU at the tenth edge after accept
    @(negedge clk_i);
    valid_i = 1'b1; md_op_i = 4'd5; op_a_i = 32'd1000; op_b_i = 32'd7;
    @(posedge clk_i); #1; valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    @(negedge clk_i); kill_i = 1'b1;
    @(posedge clk_i); #1; kill_i = 1'b0;
    chk("kill_ready", ready_o, 1);
    chk("kill_busy", busy_o, 0);
    chk("kill_result_held", result_o, last_res);
    seen = 0;
    repeat (40) begin @(posedge clk_i); #1; if (valid_o) seen = 1; end
    chk("kill_no_valid", seen, 0);
    run_op(4'd0, 32'd3, 32'd4, 0);

    // Kill while in DONE: special-case result is already registered, pulse suppressed
    @(negedge clk_i);
    valid_i = 1'b1; md_op_i = 4'd4; op_a_i = 32'd5; op_b_i = 32'd0;
    @(posedge clk_i); #1; valid_i = 1'b0; kill_i = 1'b1;
    @(posedge clk_i); #1; kill_i = 1'b0;
    chk("kill_done_valid", valid_o, 0);
    chk("kill_done_ready", ready_o, 1);
    chk("kill_done_result", result_o, 32'hFFFF_FFFF);
    last_res = 32'hFFFF_FFFF;

    // Unsupported opcode is not accepted
    @(negedge clk_i);
    valid_i = 1'b1; md_op_i = 4'd8; op_a_i = 32'd1; op_b_i = 32'd1;
    @(posedge clk_i); #1; valid_i = 1'b0;
    chk("op8_ready", ready_o, 1);
    chk("op8_busy", busy_o, 0);
    seen = 0;
    repeat (40) begin @(posedge clk_i); #1; if (valid_o) seen = 1; end
    chk("op8_no_valid", seen, 0);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 7));
      run_op(op, pick(), pick(), 0);
    end

    // Asynchronous reset in the middle of a multiply
    @(negedge clk_i);
    valid_i = 1'b1; md_op_i = 4'd3; op_a_i = 32'hDEAD_BEEF; op_b_i = 32'h1234_5678;
    @(posedge clk_i); #1; valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_ready", ready_o, 1);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_result", result_o, 0);
    @(negedge clk_i); rst_i = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk_i); #1; if (valid_o) seen = 1; end
    chk("midrst_no_valid", seen, 0);
    run_op(4'd1, 32'hFFFF_FFF0, 32'd3, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
